// File: rtl/assoc_reconfig_if.sv
// Bundle between the associativity reconfiguration controller and its
// neighbours: the predictor request/acknowledge pair plus the cache-side
// stall, scan, writeback and invalidate signals.
// master = the reconfiguration controller, slave = predictor + cache side.
interface assoc_reconfig_if #(
   parameter int SET_SIZE = 16,
   parameter int WAYS     = 4
);
   localparam int SET_W = $clog2(SET_SIZE);
   localparam int WAY_W = $clog2(WAYS);

   logic             setup_valid;
   logic             setup_update;
   logic [1:0]       setup;
   logic             setup_ready;
   logic             cache_idle;
   logic             cache_stall;
   logic [SET_W-1:0] scan_set;
   logic [WAY_W-1:0] scan_way;
   logic             line_valid;
   logic             line_dirty;
   logic             wb_req;
   logic             wb_ack;
   logic             inval_we;

   modport master (
      input  setup_valid, setup_update, cache_idle, line_valid, line_dirty, wb_ack,
      output setup, setup_ready, cache_stall, scan_set, scan_way, wb_req, inval_we
   );

   modport slave (
      output setup_valid, setup_update, cache_idle, line_valid, line_dirty, wb_ack,
      input  setup, setup_ready, cache_stall, scan_set, scan_way, wb_req, inval_we
   );
endinterface

// File: rtl/assoc_reconfig_ctrl.sv
// Associativity reconfiguration controller. Owns the committed setup code.
// An accepted up/down request stalls the cache, walks every line in
// way-minor order (writing back valid+dirty lines, invalidating all), then
// commits the new setup and acknowledges. Illegal requests are acknowledged
// immediately without touching the cache.
//
// Handshake: setup_valid is a level request held by the predictor until
// setup_ready. setup_ready is a single-cycle acknowledge, raised exactly once
// per accepted request (in S_REJECT or S_COMMIT); setup_valid seen while the
// controller is busy is ignored, and setup_update is only sampled at accept.
// wb_req is held with a stable scan index until a single-cycle wb_ack, which
// may arrive in the very first wb_req cycle.
//
// SET_SIZE and WAYS are expected to be powers of two, WAYS >= 2.
module assoc_reconfig_ctrl #(
   parameter int SET_SIZE   = 16,
   parameter int WAYS       = 4,
   parameter int MAX_SETUP  = 3,
   parameter int INIT_SETUP = 0
) (
   input  logic                clk,
   input  logic                rst,
   assoc_reconfig_if.master    bus,
   output logic [2:0]          dbg_state
);
   localparam int LINES = SET_SIZE * WAYS;
   localparam int IDX_W = $clog2(LINES);
   localparam int WAY_W = $clog2(WAYS);
   localparam logic [1:0]       MAX_CODE  = MAX_SETUP[1:0];
   localparam logic [1:0]       INIT_CODE = INIT_SETUP[1:0];
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LINES - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_REJECT = 3'd1,
      S_DRAIN  = 3'd2,
      S_READ   = 3'd3,
      S_CHECK  = 3'd4,
      S_WB     = 3'd5,
      S_INVAL  = 3'd6,
      S_COMMIT = 3'd7
   } state_t;

   state_t           state_q, state_d;
   logic             dir_q;
   logic [1:0]       setup_q;
   logic [IDX_W-1:0] idx_q;
   logic             req_legal;
   logic             last_line;

   // Legality uses the live setup and the live direction bit at accept time.
   assign req_legal = bus.setup_update ? (setup_q != 2'd0) : (setup_q < MAX_CODE);
   assign last_line = (idx_q == LAST_IDX);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (bus.setup_valid) state_d = req_legal ? S_DRAIN : S_REJECT;
         S_REJECT: state_d = S_IDLE;
         S_DRAIN:  if (bus.cache_idle) state_d = S_READ;
         S_READ:   state_d = S_CHECK;
         S_CHECK:  state_d = (bus.line_valid && bus.line_dirty) ? S_WB : S_INVAL;
         S_WB:     if (bus.wb_ack) state_d = S_INVAL;
         S_INVAL:  state_d = last_line ? S_COMMIT : S_READ;
         S_COMMIT: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Outputs decoded from state only, so async reset drops them at once.
   always_comb begin
      bus.cache_stall = 1'b0;
      bus.setup_ready = 1'b0;
      bus.wb_req      = 1'b0;
      bus.inval_we    = 1'b0;
      unique case (state_q)
         S_REJECT: bus.setup_ready = 1'b1;
         S_DRAIN, S_READ, S_CHECK: bus.cache_stall = 1'b1;
         S_WB: begin
            bus.cache_stall = 1'b1;
            bus.wb_req      = 1'b1;
         end
         S_INVAL: begin
            bus.cache_stall = 1'b1;
            bus.inval_we    = 1'b1;
         end
         S_COMMIT: begin
            bus.cache_stall = 1'b1;
            bus.setup_ready = 1'b1;
         end
         default: ;
      endcase
   end

   // Datapath: latched direction, scan index and the committed setup code.
   // Legality was checked at accept and setup is frozen until commit, so the
   // +/-1 here can never wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dir_q   <= 1'b0;
         setup_q <= INIT_CODE;
         idx_q   <= '0;
      end else begin
         if (state_q == S_IDLE && bus.setup_valid) dir_q <= bus.setup_update;
         if (state_q == S_DRAIN && bus.cache_idle) idx_q <= '0;
         else if (state_q == S_INVAL && !last_line) idx_q <= idx_q + 1'b1;
         if (state_q == S_COMMIT) setup_q <= dir_q ? (setup_q - 2'd1) : (setup_q + 2'd1);
      end
   end

   assign bus.setup    = setup_q;
   assign bus.scan_set = idx_q[IDX_W-1:WAY_W];
   assign bus.scan_way = idx_q[WAY_W-1:0];
   assign dbg_state    = state_q;
endmodule

// File: tb/tb_assoc_reconfig_ctrl.sv
// Bench for assoc_reconfig_ctrl: a line-state memory model with 1-cycle read
// latency, request/writeback drivers, and an expected queue of latencies,
// setup codes and writeback addresses.
module tb_assoc_reconfig_ctrl;
  localparam int SET_SIZE = 16;
  localparam int WAYS     = 4;
  localparam int LINES    = SET_SIZE * WAYS;
  localparam int CLEAN_LAT = 3 * LINES + 2;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_READ = 3'd3;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  logic [2:0] dbg_state;
  int cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assoc_reconfig_if #(.SET_SIZE(SET_SIZE), .WAYS(WAYS)) bus ();

  assoc_reconfig_ctrl #(
    .SET_SIZE(SET_SIZE), .WAYS(WAYS), .MAX_SETUP(3), .INIT_SETUP(0)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
  );

  // cache line state model
  logic mem_v [LINES];
  logic mem_d [LINES];
  logic plant_we;
  logic [5:0] plant_idx;
  logic plant_v, plant_d;
  logic [5:0] scan_idx;
  assign scan_idx = {bus.scan_set, bus.scan_way};

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LINES; i++) begin
        mem_v[i] <= 1'b0;
        mem_d[i] <= 1'b0;
      end
      bus.line_valid <= 1'b0;
      bus.line_dirty <= 1'b0;
    end else begin
      bus.line_valid <= mem_v[scan_idx];
      bus.line_dirty <= mem_d[scan_idx];
      if (bus.inval_we) begin
        mem_v[scan_idx] <= 1'b0;
        mem_d[scan_idx] <= 1'b0;
      end
      if (plant_we) begin
        mem_v[plant_idx] <= plant_v;
        mem_d[plant_idx] <= plant_d;
      end
    end
  end

  // scoreboard
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_setup_q[$];
  logic [5:0]  wb_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic plant(input int idx, input logic v, input logic d);
    @(negedge clk);
    plant_we  = 1'b1;
    plant_idx = 6'(idx);
    plant_v   = v;
    plant_d   = d;
    @(negedge clk);
    plant_we  = 1'b0;
  endtask

  task automatic do_req(input string tag, input logic dir, input logic legal,
                        input int idle_dly, input int ack_dly,
                        input int exp_inval, input int exp_wb);
    int acc, n, n_inv, n_wbw, stall_bad, hold_bad, early, wb_cnt, first_read;
    logic seen, prev_wb;
    logic [5:0] held;
    logic [31:0] e_lat, e_setup;
    n_inv = 0; n_wbw = 0; stall_bad = 0; hold_bad = 0; early = 0;
    wb_cnt = 0; first_read = 0; seen = 1'b0; prev_wb = 1'b0; held = '0; n = 0;
    @(negedge clk);
    if (idle_dly > 0) bus.cache_idle = 1'b0;
    bus.setup_valid  = 1'b1;
    bus.setup_update = dir;
    acc = cyc + 1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      n = cyc - acc + 1;
      if (!bus.cache_idle && (bus.inval_we || bus.wb_req)) early++;
      if (idle_dly > 0 && n == idle_dly + 1) bus.cache_idle = 1'b1;
      if (legal != bus.cache_stall) stall_bad++;
      if (bus.inval_we) n_inv++;
      if (first_read == 0 && dbg_state == ST_READ) first_read = n;
      if (bus.wb_req) begin
        if (!prev_wb) begin
          n_wbw++;
          held = scan_idx;
          if (wb_q.size() > 0) check({tag, "_wb_addr"}, 32'(scan_idx), 32'(wb_q.pop_front()));
        end else if (scan_idx != held) begin
          hold_bad++;
        end
        wb_cnt++;
        bus.wb_ack = (wb_cnt == ack_dly + 1);
      end else begin
        wb_cnt = 0;
        bus.wb_ack = 1'b0;
      end
      prev_wb = bus.wb_req;
      if (bus.setup_ready) begin
        seen = 1'b1;
        break;
      end
    end
    e_lat   = exp_q.pop_front();
    e_setup = exp_setup_q.pop_front();
    check({tag, "_ready_seen"}, 32'(seen), 32'd1);
    if (seen) check({tag, "_latency"}, 32'(n), e_lat);
    bus.setup_valid = 1'b0;
    bus.wb_ack      = 1'b0;
    bus.cache_idle  = 1'b1;
    @(negedge clk);
    check({tag, "_setup"}, 32'(bus.setup), e_setup);
    check({tag, "_ready_one_cycle"}, 32'(bus.setup_ready), 32'd0);
    check({tag, "_stall_after"}, 32'(bus.cache_stall), 32'd0);
    check({tag, "_stall_window"}, 32'(stall_bad), 32'd0);
    check({tag, "_inval_pulses"}, 32'(n_inv), 32'(exp_inval));
    check({tag, "_wb_windows"}, 32'(n_wbw), 32'(exp_wb));
    check({tag, "_wb_hold"}, 32'(hold_bad), 32'd0);
    check({tag, "_scan_before_idle"}, 32'(early), 32'd0);
    if (legal) check({tag, "_first_read"}, 32'(first_read), 32'(idle_dly + 2));
  endtask

  // main sequence
  initial begin
    int d, a, b, c, k;
    logic reached;
    rst = 1'b1;
    bus.setup_valid = 1'b0; bus.setup_update = 1'b0;
    bus.cache_idle = 1'b1; bus.wb_ack = 1'b0;
    plant_we = 1'b0; plant_idx = '0; plant_v = 1'b0; plant_d = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_setup", 32'(bus.setup), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_stall", 32'(bus.cache_stall), 32'd0);
    check("rst_ready", 32'(bus.setup_ready), 32'd0);
    check("rst_wb_req", 32'(bus.wb_req), 32'd0);
    check("rst_inval", 32'(bus.inval_we), 32'd0);
    check("rst_scan", 32'(scan_idx), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // downscale at setup 0 is rejected
    exp_q.push_back(32'd1); exp_setup_q.push_back(32'd0);
    do_req("rej_down", 1'b1, 1'b0, 0, 0, 0, 0);

    // clean upscale 0 -> 1
    exp_q.push_back(32'(CLEAN_LAT)); exp_setup_q.push_back(32'd1);
    do_req("up_clean", 1'b0, 1'b1, 0, 0, LINES, 0);

    // dirty lines (3,2) and (15,3), ack 5 cycles after wb_req
    plant(3 * WAYS + 2, 1'b1, 1'b1);
    plant(15 * WAYS + 3, 1'b1, 1'b1);
    wb_q.push_back(6'(3 * WAYS + 2));
    wb_q.push_back(6'(15 * WAYS + 3));
    exp_q.push_back(32'(CLEAN_LAT + 2 * 6)); exp_setup_q.push_back(32'd2);
    do_req("up_dirty", 1'b0, 1'b1, 0, 5, LINES, 2);

    // cache busy for 10 cycles after accept
    exp_q.push_back(32'(CLEAN_LAT + 10)); exp_setup_q.push_back(32'd3);
    do_req("up_idle", 1'b0, 1'b1, 10, 0, LINES, 0);

    // upscale at MAX rejected, then downscale
    exp_q.push_back(32'd1); exp_setup_q.push_back(32'd3);
    do_req("rej_up", 1'b0, 1'b0, 0, 0, 0, 0);
    exp_q.push_back(32'(CLEAN_LAT)); exp_setup_q.push_back(32'd2);
    do_req("down", 1'b1, 1'b1, 0, 0, LINES, 0);

    // random dirty lines and ack delay; dirty-but-invalid and clean-valid lines add nothing
    d = $urandom_range(0, 3);
    a = $urandom_range(1, 20);
    b = $urandom_range(22, 41);
    c = $urandom_range(42, 63);
    plant(0, 1'b0, 1'b1);
    plant(21, 1'b1, 1'b0);
    plant(a, 1'b1, 1'b1);
    plant(b, 1'b1, 1'b1);
    plant(c, 1'b1, 1'b1);
    wb_q.push_back(6'(a)); wb_q.push_back(6'(b)); wb_q.push_back(6'(c));
    exp_q.push_back(32'(CLEAN_LAT + 3 * (d + 1))); exp_setup_q.push_back(32'd1);
    do_req("down_rand", 1'b1, 1'b1, 0, d, LINES, 3);

    // async reset while waiting in writeback
    plant(5, 1'b1, 1'b1);
    @(negedge clk);
    bus.setup_valid = 1'b1; bus.setup_update = 1'b0;
    reached = 1'b0;
    for (k = 0; k < 400; k++) begin
      @(negedge clk);
      if (bus.wb_req) begin
        reached = 1'b1;
        break;
      end
    end
    check("rst_mid_wb_reached", 32'(reached), 32'd1);
    check("rst_mid_pre_setup", 32'(bus.setup), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_wb_req", 32'(bus.wb_req), 32'd0);
    check("rst_mid_stall", 32'(bus.cache_stall), 32'd0);
    check("rst_mid_setup", 32'(bus.setup), 32'd0);
    check("rst_mid_inval", 32'(bus.inval_we), 32'd0);
    bus.setup_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_mid_setup_after", 32'(bus.setup), 32'd0);
    check("rst_mid_scan", 32'(scan_idx), 32'd0);

    // final report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
